// File: rtl/pp_pipeline_accel_ctrl_pkg.sv
// Shared types and defaults for the pre-processing frame controller.
package pp_pipeline_accel_ctrl_pkg;

   localparam int unsigned DefDimW = 11;
   localparam int unsigned DefCntW = 16;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StBcast,
      StWait,
      StDone
   } ctrl_state_e;

endpackage

// File: rtl/pp_pipeline_accel_mask_tracker.sv
// Per-consumer set/clear mask; all_set also counts bits being set this cycle.
module pp_pipeline_accel_mask_tracker #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             clr,
   input  logic [WIDTH-1:0] set,
   output logic [WIDTH-1:0] mask,
   output logic             all_set
);

   logic [WIDTH-1:0] mask_q;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         mask_q <= '0;
      end else if (clr) begin
         mask_q <= '0;
      end else begin
         mask_q <= mask_q | set;
      end
   end

   assign mask    = mask_q;
   assign all_set = &(mask_q | set);

endmodule

// File: rtl/pp_pipeline_accel_dim_bcast_ctrl.sv
// Frame sequencer: pops one (rows, cols) pair, broadcasts it, waits for all consumer dones.
// Optional PP_PIPELINE_ACCEL_DIM_CHECK_EN: zero dimensions skip the frame and set dim_err.
module pp_pipeline_accel_dim_bcast_ctrl
   import pp_pipeline_accel_ctrl_pkg::*;
#(
   parameter int unsigned DIM_W    = DefDimW,
   parameter int unsigned NUM_CONS = 3,
   parameter int unsigned CNT_W    = DefCntW
) (
   input  logic                ap_clk,
   input  logic                ap_rst_n,
   input  logic                ap_start,
   input  logic                ap_continue,
   output logic                ap_idle,
   output logic                ap_ready,
   output logic                ap_done,
   input  logic [DIM_W-1:0]    rows_dout,
   input  logic                rows_empty_n,
   output logic                rows_read,
   input  logic [DIM_W-1:0]    cols_dout,
   input  logic                cols_empty_n,
   output logic                cols_read,
   output logic [DIM_W-1:0]    dim_rows,
   output logic [DIM_W-1:0]    dim_cols,
   input  logic [NUM_CONS-1:0] cons_full_n,
   output logic [NUM_CONS-1:0] cons_write,
   input  logic [NUM_CONS-1:0] cons_done,
   output logic [CNT_W-1:0]    frame_cnt,
   output logic                dim_err
);

   ctrl_state_e state_q, state_d;
   logic [DIM_W-1:0]    dim_rows_q, dim_cols_q;
   logic [CNT_W-1:0]    frame_cnt_q;
   logic [NUM_CONS-1:0] sent_mask, sent_set, done_mask, done_set;
   logic                sent_all, done_all, mask_clr, latch, cnt_inc;

   pp_pipeline_accel_mask_tracker #(
      .WIDTH(NUM_CONS)
   ) u_sent (
      .ap_clk  (ap_clk),
      .ap_rst_n(ap_rst_n),
      .clr     (mask_clr),
      .set     (sent_set),
      .mask    (sent_mask),
      .all_set (sent_all)
   );

   pp_pipeline_accel_mask_tracker #(
      .WIDTH(NUM_CONS)
   ) u_done (
      .ap_clk  (ap_clk),
      .ap_rst_n(ap_rst_n),
      .clr     (mask_clr),
      .set     (done_set),
      .mask    (done_mask),
      .all_set (done_all)
   );

`ifdef PP_PIPELINE_ACCEL_DIM_CHECK_EN
   logic dim_err_q, err_set, dim_zero;
   assign dim_zero = (rows_dout == '0) || (cols_dout == '0);
`endif

   always_comb begin
      state_d    = state_q;
      ap_idle    = 1'b0;
      ap_ready   = 1'b0;
      ap_done    = 1'b0;
      rows_read  = 1'b0;
      cols_read  = 1'b0;
      cons_write = '0;
      sent_set   = '0;
      done_set   = '0;
      mask_clr   = 1'b0;
      latch      = 1'b0;
      cnt_inc    = 1'b0;
`ifdef PP_PIPELINE_ACCEL_DIM_CHECK_EN
      err_set    = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            ap_idle = ~ap_start;
            if (ap_start) state_d = StFetch;
         end
         StFetch: begin
            if (!ap_start) begin
               state_d = StIdle;
            end else if (rows_empty_n && cols_empty_n) begin
               rows_read = 1'b1;
               cols_read = 1'b1;
               ap_ready  = 1'b1;
               latch     = 1'b1;
               mask_clr  = 1'b1;
               state_d   = StBcast;
`ifdef PP_PIPELINE_ACCEL_DIM_CHECK_EN
               if (dim_zero) begin
                  err_set = 1'b1;
                  state_d = StDone;
               end
`endif
            end
         end
         StBcast: begin
            cons_write = ~sent_mask & cons_full_n;
            sent_set   = cons_write;
            // A done only counts once that consumer has been handed the descriptor.
            done_set   = cons_done & (sent_mask | cons_write) & ~done_mask;
            if (sent_all) state_d = StWait;
         end
         StWait: begin
            done_set = cons_done;
            if (done_all) begin
               state_d = StDone;
               cnt_inc = 1'b1;
            end
         end
         StDone: begin
            ap_done = 1'b1;
            if (ap_continue) state_d = ap_start ? StFetch : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= StIdle;
         dim_rows_q  <= '0;
         dim_cols_q  <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (latch) begin
            dim_rows_q <= rows_dout;
            dim_cols_q <= cols_dout;
         end
         if (cnt_inc) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
   end

`ifdef PP_PIPELINE_ACCEL_DIM_CHECK_EN
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         dim_err_q <= 1'b0;
      end else if (err_set) begin
         dim_err_q <= 1'b1;
      end
   end
   assign dim_err = dim_err_q;
`else
   assign dim_err = 1'b0;
`endif

   assign dim_rows  = dim_rows_q;
   assign dim_cols  = dim_cols_q;
   assign frame_cnt = frame_cnt_q;

endmodule
